// File: rtl/nibble_unpacker.sv
// nibble_unpacker: splits each accepted byte into two 4-bit nibbles with a
// valid/ready handshake on both sides and counts fully emitted bytes.
// Optional build macro NIBBLE_UNPACKER_LO_FIRST_EN: emit the low nibble first
// instead of the default high-nibble-first order.
module nibble_unpacker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [3:0]       nib_first;
  logic [3:0]       nib_second;

  // Nibble ordering is fixed at build time; only the mapping differs.
`ifdef NIBBLE_UNPACKER_LO_FIRST_EN
  assign nib_first  = hold_q[3:0];
  assign nib_second = hold_q[7:4];
`else
  assign nib_first  = hold_q[7:4];
  assign nib_second = hold_q[3:0];
`endif

  // Handshake and output decode: a new byte may enter when the hold register
  // is empty or its last nibble is leaving this cycle; never while in reset.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 4'h0;
    out_last   = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = ~rst;
      end
      FIRST: begin
        out_valid = 1'b1;
        out_data  = nib_first;
      end
      SECOND: begin
        in_ready  = ~rst & out_ready;
        out_valid = 1'b1;
        out_data  = nib_second;
        out_last  = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign byte_count = cnt_q;

  // Next-state logic: advance on downstream acceptance, reload the hold
  // register on every input transfer so SECOND->FIRST needs no bubble.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (in_valid) state_d = FIRST;
      end
      FIRST: begin
        if (out_ready) state_d = SECOND;
      end
      SECOND: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = in_valid ? FIRST : EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (accept) hold_d = in_data;
  end

  // State registers; reset wins over any handshake in the same cycle and
  // drops whatever byte was partially emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      hold_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nibble_unpacker.sv
// tb_nibble_unpacker: directed and random stimulus against a queue-based
// model of the nibble stream. Two DUTs share stimulus: default counter width
// and a 2-bit counter to exercise wrap-around.
module tb_nibble_unpacker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic [7:0] byte_count;

  logic       in_ready2;
  logic       out_valid2;
  logic [3:0] out_data2;
  logic       out_last2;
  logic [1:0] byte_count2;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] d;
    logic       l;
  } nib_t;

  nib_t nq[$];
  int   model_cnt;

  nibble_unpacker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .byte_count(byte_count)
  );

  nibble_unpacker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_last(out_last2), .byte_count(byte_count2)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare against the model,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    logic       expReady;
    logic       expValid;
    logic [3:0] expData;
    logic       expLast;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    expValid = (nq.size() != 0);
    expData  = expValid ? nq[0].d : 4'h0;
    expLast  = expValid ? nq[0].l : 1'b0;
    expReady = !r && (nq.size() == 0 || (nq.size() == 1 && ordy));
    checkOutput("in_ready",    {7'd0, in_ready},   {7'd0, expReady});
    checkOutput("out_valid",   {7'd0, out_valid},  {7'd0, expValid});
    checkOutput("out_data",    {4'd0, out_data},   {4'd0, expData});
    checkOutput("out_last",    {7'd0, out_last},   {7'd0, expLast});
    checkOutput("byte_count",  byte_count,         8'(model_cnt % 256));
    checkOutput("byte_count2", {6'd0, byte_count2}, 8'(model_cnt % 4));
    checkOutput("in_ready2",   {7'd0, in_ready2},  {7'd0, expReady});
    @(posedge clk);
    if (r) begin
      nq.delete();
      model_cnt = 0;
    end else begin
      if (expValid && ordy) begin
        if (nq[0].l) model_cnt++;
        void'(nq.pop_front());
      end
      if (iv && expReady) begin
`ifdef NIBBLE_UNPACKER_LO_FIRST_EN
        nq.push_back('{d: d[3:0], l: 1'b0});
        nq.push_back('{d: d[7:4], l: 1'b1});
`else
        nq.push_back('{d: d[7:4], l: 1'b0});
        nq.push_back('{d: d[3:0], l: 1'b1});
`endif
      end
    end
  endtask

  // Directed scenarios followed by a random backpressure soak.
  initial begin
    checks    = 0;
    failures  = 0;
    model_cnt = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1);

    // Single byte 0xF5 with downstream always ready.
    applyStimulus(1'b0, 1'b1, 8'hF5, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Back-to-back bytes 0xA5, 0x3C with no bubble.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Byte 0x0E held under five cycles of backpressure.
    applyStimulus(1'b0, 1'b1, 8'h0E, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset while presenting the second nibble of 0x81.
    applyStimulus(1'b0, 1'b1, 8'h81, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Five streamed bytes to walk the 2-bit counter through its wrap.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Low-first build check on 0x7F (the model follows the active build).
    applyStimulus(1'b0, 1'b1, 8'h7F, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    8'($urandom),
                    ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
